vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 160, meaning screen width in pixels.
REQ-002 The block SHALL have parameter H, default 120, meaning screen height in pixels.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning CPU write FIFO depth in entries.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port wr, input, 1 bit, CPU pixel-write strobe, one entry per high cycle.
REQ-007 The block SHALL have port x, input, 8 bits, CPU pixel column.
REQ-008 The block SHALL have port y, input, 8 bits, CPU pixel row.
REQ-009 The block SHALL have port color, input, 3 bits, CPU pixel colour.
REQ-010 The block SHALL have port clr, input, 1 bit, screen-clear request strobe.
REQ-011 The block SHALL have port clr_color, input, 3 bits, fill colour, sampled with clr.
REQ-012 The block SHALL have port ack, input, 1 bit, clears the ovf and err sticky flags.
REQ-013 The block SHALL have port mem_we, output, 1 bit, video-memory write enable.
REQ-014 The block SHALL have port mem_addr, output, 15 bits, video-memory address, y*W+x.
REQ-015 The block SHALL have port mem_data, output, 3 bits, video-memory write colour.
REQ-016 The block SHALL have port full, output, 1 bit, FIFO holds DEPTH entries.
REQ-017 The block SHALL have port busy, output, 1 bit, high while in CLEAR or while the FIFO is non-empty.
REQ-018 The block SHALL have port ovf, output, 1 bit, sticky flag: a write was dropped because the FIFO was full.
REQ-019 The block SHALL have port err, output, 1 bit, sticky flag: a write was dropped for out-of-range coordinates.

Function
REQ-020 The state machine SHALL have two states: IDLE (serve FIFO) and CLEAR (fill screen).
REQ-021 All outputs SHALL be registered; mem_we SHALL be high for exactly one cycle per memory write.
REQ-022 A write with wr=1, x<W, y<H and the FIFO not full at edge k SHALL be pushed with its computed address and colour.
REQ-023 A write with x>=W or y>=H SHALL NOT be pushed; err SHALL be set at the same edge; the range check takes precedence over the full check.
REQ-024 An in-range write arriving while full=1 SHALL be dropped and ovf SHALL be set, even if a pop occurs in the same cycle.
REQ-025 In IDLE with the FIFO non-empty, the oldest entry SHALL be popped each edge and drive mem_we/mem_addr/mem_data in the following cycle.
REQ-026 With an empty FIFO in IDLE, a write pushed at edge k SHALL appear on mem_we after edge k+1, i.e. one-cycle latency; sustained throughput SHALL be one write per cycle.
REQ-027 Simultaneous push and pop in a non-full FIFO SHALL keep the count unchanged; order SHALL be strictly FIFO.
REQ-028 clr=1 in IDLE SHALL latch clr_color, flush all FIFO entries present before that edge, set the address counter to 0, and enter CLEAR.
REQ-029 A write arriving in the same cycle as an accepted clr SHALL be retained and executed after the clear.
REQ-030 In CLEAR, one write per cycle SHALL be issued for addresses 0..W*H-1 with the latched colour; FIFO pops SHALL be suspended while pushes continue.
REQ-031 After address W*H-1 is issued, the block SHALL return to IDLE and resume FIFO service on the next edge.
REQ-032 clr=1 during CLEAR SHALL restart the counter at 0 with the newly latched colour; the FIFO SHALL NOT be flushed.
REQ-033 ack=1 SHALL clear ovf and err; a set event in the same cycle as ack SHALL win.
REQ-034 full SHALL reflect the count after the current edge; busy SHALL be low only in IDLE with an empty FIFO.

Reset
REQ-035 When reset=0, the block SHALL asynchronously enter IDLE, empty the FIFO, zero the counter, and drive mem_we=0, mem_addr=0, mem_data=0, full=0, busy=0, ovf=0 and err=0.
REQ-036 Reset asserted mid-CLEAR or mid-drain SHALL abort the operation with no further mem_we until new requests arrive after reset release.

Verification
REQ-037 Single write: wr with x=3, y=2, color=5 at edge k -> mem_we=1, mem_addr=323, mem_data=5 after edge k+1, then mem_we=0.
REQ-038 Range check: wr with x=160, y=0 -> no mem_we and err=1; after ack, err=0.
REQ-039 Overflow: clr, then 5 in-range writes during CLEAR -> full=1 after the 4th write, 5th dropped, ovf=1; after the clear the 4 entries drain in order on consecutive cycles.
REQ-040 Full clear: clr with clr_color=2 -> 19200 consecutive mem_we cycles, addresses 0..19199, data=2, then busy=0.
REQ-041 Simultaneous events: clr and a write (x=0, y=0, color=7) in the same cycle with 2 entries pending -> the pending entries are flushed, the clear runs, then a single write to address 0 with data 7.
REQ-042 Reset mid-clear: reset=0 at counter 500 -> all outputs return to 0 immediately; no mem_we after release.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// Arbitrates CPU pixel writes (through a small FIFO) against a full-screen clear
// engine, producing one registered video-memory write per cycle at most.
module vga_write_arbiter #(
    parameter int W     = 160,
    parameter int H     = 120,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  color,
    input  logic        clr,
    input  logic [2:0]  clr_color,
    input  logic        ack,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        full,
    output logic        busy,
    output logic        ovf,
    output logic        err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [14:0]   LAST_ADDR = 15'(W * H - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_next;
    logic [PW-1:0] head, head_next;
    logic [PW-1:0] tail, tail_next;
    logic [CW-1:0] count, count_next;
    logic [14:0]   clr_addr;
    logic [2:0]    fill_color;
    logic [17:0]   fifo_mem [DEPTH];

    logic          in_range;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          flush;
    logic [14:0]   push_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_range  = (32'(x) < 32'(W)) && (32'(y) < 32'(H));
    assign fifo_full = (count == DEPTH_C);
    assign push      = wr && in_range && !fifo_full;
    assign flush     = (state == IDLE) && clr;
    assign pop       = (state == IDLE) && !clr && (count != '0);
    assign push_addr = 15'(y) * 15'(W) + 15'(x);

    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        state_next = state;

        // A flush discards everything queued before this edge; a same-cycle push survives it.
        if (flush) begin
            head_next  = tail;
            count_next = CW'(push);
        end else begin
            if (pop) begin
                head_next = ptr_inc(head);
            end
            count_next = count + CW'(push) - CW'(pop);
        end
        if (push) begin
            tail_next = ptr_inc(tail);
        end

        case (state)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (!clr && clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= {push_addr, color};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            clr_addr   <= '0;
            fill_color <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            full       <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            busy  <= (state_next == CLEAR) || (count_next != '0);

            // A clr edge (new or restart) issues nothing; the sweep starts on the next edge.
            if (clr) begin
                fill_color <= clr_color;
                clr_addr   <= '0;
                mem_we     <= 1'b0;
            end else if (state == CLEAR) begin
                mem_we   <= 1'b1;
                mem_addr <= clr_addr;
                mem_data <= fill_color;
                clr_addr <= clr_addr + 15'd1;
            end else if (pop) begin
                mem_we   <= 1'b1;
                mem_addr <= fifo_mem[head][17:3];
                mem_data <= fifo_mem[head][2:0];
            end else begin
                mem_we <= 1'b0;
            end

            // Set events take priority over ack.
            if (wr && in_range && fifo_full) begin
                ovf <= 1'b1;
            end else if (ack) begin
                ovf <= 1'b0;
            end
            if (wr && !in_range) begin
                err <= 1'b1;
            end else if (ack) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts every memory write and
// flag value; a monitor compares the DUT against it one time step after each edge.
module tb_vga_write_arbiter;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic [2:0]  color = '0;
    logic        clr = 1'b0;
    logic [2:0]  clr_color = '0;
    logic        ack = 1'b0;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        full;
    logic        busy;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    vga_write_arbiter #(.W(W), .H(H), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .x(x), .y(y), .color(color),
        .clr(clr), .clr_color(clr_color), .ack(ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .full(full), .busy(busy), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state: pending CPU writes and expected memory writes as {addr, data}.
    logic [17:0] fifo_q[$];
    logic [17:0] exp_q[$];
    bit          m_clearing = 1'b0;
    int          m_pos = 0;
    logic [2:0]  m_ccol = '0;
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;

    bit counting = 1'b0;
    int we_cnt = 0;
    int gaps = 0;

    task automatic check_eq(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_step();
        bit in_rng;
        bit was_full;
        if (!reset) begin
            fifo_q.delete();
            exp_q.delete();
            m_clearing = 1'b0;
            m_pos = 0;
            m_ccol = '0;
            m_ovf = 1'b0;
            m_err = 1'b0;
        end else begin
            in_rng = (int'(x) < W) && (int'(y) < H);
            was_full = (fifo_q.size() == DEPTH);
            if (clr) begin
                if (!m_clearing) fifo_q.delete();
                m_clearing = 1'b1;
                m_pos = 0;
                m_ccol = clr_color;
            end else if (m_clearing) begin
                exp_q.push_back({15'(m_pos), m_ccol});
                m_pos++;
                if (m_pos == W * H) m_clearing = 1'b0;
            end else if (fifo_q.size() > 0) begin
                exp_q.push_back(fifo_q.pop_front());
            end
            if (wr && in_rng && !was_full) fifo_q.push_back({15'(int'(y) * W + int'(x)), color});
            if (wr && in_rng && was_full) m_ovf = 1'b1;
            else if (ack) m_ovf = 1'b0;
            if (wr && !in_rng) m_err = 1'b1;
            else if (ack) m_err = 1'b0;
        end
    endtask

    task automatic monitor_step();
        logic [17:0] e;
        bit m_full;
        bit m_busy;
        if (counting) begin
            if (mem_we) we_cnt++;
            else if (we_cnt > 0) gaps++;
        end
        if (mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} != e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             mem_addr, mem_data, e[17:3], e[2:0]);
                end
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_write: got mem_we=0, expected addr=%0d data=%0d", e[17:3], e[2:0]);
        end
        m_full = (fifo_q.size() == DEPTH);
        m_busy = m_clearing || (fifo_q.size() > 0);
        check_eq("flags{full,busy,ovf,err}", longint'({full, busy, ovf, err}),
                 longint'({m_full, m_busy, m_ovf, m_err}));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        monitor_step();
    end

    task automatic wait_busy_low(input int limit, input string name);
        for (int i = 0; i < limit && busy; i++) @(negedge clk);
        check_eq(name, longint'(busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", longint'({mem_we, mem_addr, mem_data, full, busy, ovf, err}), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single write: address 2*160+3 = 323, one-cycle latency, single pulse
        wr = 1'b1; x = 8'd3; y = 8'd2; color = 3'd5;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        check_eq("single_write", longint'({mem_we, mem_addr, mem_data}), longint'({1'b1, 15'd323, 3'd5}));
        @(negedge clk);
        check_eq("single_write_pulse", longint'(mem_we), 0);

        // Range check, ack, and set-wins-over-ack
        wr = 1'b1; x = 8'd160; y = 8'd0;
        @(negedge clk);
        wr = 1'b0;
        check_eq("range_err_set", longint'(err), 1);
        @(negedge clk);
        check_eq("range_no_write", longint'(mem_we), 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_eq("range_err_ack", longint'(err), 0);
        wr = 1'b1; x = 8'd0; y = 8'd120; ack = 1'b1;
        @(negedge clk);
        wr = 1'b0; ack = 1'b0;
        check_eq("err_set_wins_ack", longint'(err), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Full clear with colour 2, overflow during clear, drain afterwards
        counting = 1'b1; we_cnt = 0; gaps = 0;
        clr = 1'b1; clr_color = 3'd2;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; x = 8'(10 + i); y = 8'(20 + i); color = 3'(i + 1);
            @(negedge clk);
            if (i == 2) check_eq("full_after_3", longint'(full), 0);
            if (i == 3) check_eq("full_ovf_after_4", longint'({full, ovf}), longint'(2'b10));
            if (i == 4) check_eq("full_ovf_after_5", longint'({full, ovf}), longint'(2'b11));
        end
        wr = 1'b0;
        wait_busy_low(25000, "clear_done_busy");
        counting = 1'b0;
        check_eq("clear_write_count", we_cnt, W * H + 4);
        check_eq("clear_write_gaps", gaps, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_eq("ovf_ack", longint'(ovf), 0);

        // Restart during clear, then clr + write with two entries pending
        counting = 1'b1; we_cnt = 0; gaps = 0;
        clr = 1'b1; clr_color = 3'd1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; x = 8'(100 + i); y = 8'd50; color = 3'(3 + i);
            @(negedge clk);
        end
        wr = 1'b0;
        for (int i = 0; i < 200 && m_pos != 50; i++) @(negedge clk);
        check_eq("restart_point", m_pos, 50);
        clr = 1'b1; clr_color = 3'd6;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 25000 && !(!m_clearing && fifo_q.size() == 2); i++) @(negedge clk);
        check_eq("two_pending", longint'(fifo_q.size()), 2);
        clr = 1'b1; clr_color = 3'd4; wr = 1'b1; x = 8'd0; y = 8'd0; color = 3'd7;
        @(negedge clk);
        clr = 1'b0; wr = 1'b0;
        wait_busy_low(25000, "simul_busy");
        check_eq("simul_final_write", longint'({mem_we, mem_addr, mem_data}), longint'({1'b1, 15'd0, 3'd7}));
        counting = 1'b0;
        check_eq("simul_write_count", we_cnt, 50 + W * H + 1 + W * H + 1);

        // Reset at counter 500 aborts the clear
        clr = 1'b1; clr_color = 3'd5;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 1000 && m_pos != 500; i++) @(negedge clk);
        check_eq("reset_point", m_pos, 500);
        reset = 1'b0;
        #1;
        check_eq("reset_mid_clear", longint'({mem_we, mem_addr, mem_data, full, busy, ovf, err}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        counting = 1'b1; we_cnt = 0;
        repeat (50) @(negedge clk);
        counting = 1'b0;
        check_eq("no_write_after_reset", we_cnt, 0);

        // Randomized CPU traffic with occasional out-of-range writes and acks
        for (int i = 0; i < 2000; i++) begin
            wr = ($urandom_range(0, 9) < 6);
            x = 8'($urandom_range(0, 170));
            y = 8'($urandom_range(0, 127));
            color = 3'($urandom);
            ack = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        wr = 1'b0; ack = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("final_idle", longint'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
